// File: rtl/ps16_bus_cycle.sv
// ps16_bus_cycle: Amiga-side 68000 asynchronous bus cycle engine for PiStorm16.
// Takes a latched request from the Pi register interface and runs one (or, for
// long transfers, two back-to-back) 68000 word cycles on the 7 MHz bus.
//
// Ports:
//   sys_clk, sys_rst            system clock, synchronous active-high reset
//   mc_clk_rising/_falling      one-sys_clk strobes marking CLK_7M edges
//   dtack_sync, berr_n_sync     synchronized nDTACK / nBERR (active low)
//   is_bm                       bus ownership; gates new starts only
//   req_start, req_*            request pulse and payload
//   d_in                        Amiga data bus input
//   req_active, req_terminated_normally, req_data_read   status / result
//   a_out, fc_out, d_out, rw_out, uds_n, lds_n           bus levels
//   abus_drive, dbus_drive, rw_drive, as_drive, ds_drive bus output enables
//
// Optional feature: define PS16_BUS_TIMEOUT_EN to abort a cycle after
// TIMEOUT_CLKS wait clocks (same outcome as BERR).
module ps16_bus_cycle #(
  parameter int unsigned TIMEOUT_CLKS = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        mc_clk_rising,
  input  logic        mc_clk_falling,
  input  logic        dtack_sync,
  input  logic        berr_n_sync,
  input  logic        is_bm,
  input  logic        req_start,
  input  logic [23:0] req_address,
  input  logic [2:0]  req_fc,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_data_write,
  input  logic [15:0] d_in,
  output logic        req_active,
  output logic        req_terminated_normally,
  output logic [31:0] req_data_read,
  output logic [22:0] a_out,
  output logic [2:0]  fc_out,
  output logic [15:0] d_out,
  output logic        abus_drive,
  output logic        dbus_drive,
  output logic        rw_out,
  output logic        rw_drive,
  output logic        as_drive,
  output logic        ds_drive,
  output logic        uds_n,
  output logic        lds_n
);

  localparam int unsigned AW = 24;
  localparam int unsigned BW = 16;
  localparam int unsigned RW = 32;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ARM, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      fc_q, fc_d;
  logic            rw_q, rw_d;
  logic [1:0]      size_q, size_d;
  logic [RW-1:0]   wdata_q, wdata_d;
  logic            widx_q, widx_d;

  logic            active_d, normal_d;
  logic [RW-1:0]   rdata_d;
  logic [AW-2:0]   a_d;
  logic [2:0]      fco_d;
  logic [BW-1:0]   do_d;
  logic            abus_d, dbus_d, rwo_d, rwdrv_d, as_d, ds_d, uds_d, lds_d;
  logic            abort;

`ifdef PS16_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CLKS < 256) ? 8 : $clog2(TIMEOUT_CLKS + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CLKS);
`endif

  // Request decode: size 3 behaves as word.
  logic          is_byte, is_long, uds_sel_n, lds_sel_n;
  logic [BW-1:0] wr_word;
  logic [RW-1:0] rd_merge;

  assign is_byte   = (size_q == 2'd0);
  assign is_long   = (size_q == 2'd2);
  // Byte at even address uses UDS (D15..D8), odd address uses LDS (D7..D0).
  assign uds_sel_n = is_byte & addr_q[0];
  assign lds_sel_n = is_byte & ~addr_q[0];
  assign wr_word   = is_byte ? {wdata_q[7:0], wdata_q[7:0]} :
                     (is_long && !widx_q) ? wdata_q[31:16] : wdata_q[15:0];
  assign rd_merge  = is_byte ? {24'h0, (addr_q[0] ? d_in[7:0] : d_in[15:8])} :
                     is_long ? (widx_q ? {req_data_read[31:16], d_in}
                                       : {d_in, req_data_read[15:0]}) :
                               {16'h0, d_in};

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fc_d     = fc_q;
    rw_d     = rw_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    widx_d   = widx_q;
    active_d = req_active;
    normal_d = req_terminated_normally;
    rdata_d  = req_data_read;
    a_d      = a_out;
    fco_d    = fc_out;
    do_d     = d_out;
    abus_d   = abus_drive;
    dbus_d   = dbus_drive;
    rwo_d    = rw_out;
    rwdrv_d  = rw_drive;
    as_d     = as_drive;
    ds_d     = ds_drive;
    uds_d    = uds_n;
    lds_d    = lds_n;
    abort    = 1'b0;
`ifdef PS16_BUS_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Idle owns nothing; this also completes the release after an abort.
        abus_d  = 1'b0;
        dbus_d  = 1'b0;
        rwdrv_d = 1'b0;
        as_d    = 1'b0;
        ds_d    = 1'b0;
        rwo_d   = 1'b1;
        uds_d   = 1'b1;
        lds_d   = 1'b1;
        if (req_start && is_bm) begin
          addr_d   = req_address;
          fc_d     = req_fc;
          rw_d     = req_rw;
          size_d   = req_size;
          wdata_d  = req_data_write;
          widx_d   = 1'b0;
          active_d = 1'b1;
          state_d  = ST_ARM;
        end
      end
      ST_ARM: begin
        if (mc_clk_rising) begin
          fco_d   = fc_q;
          rwo_d   = rw_q;
          abus_d  = 1'b1;
          rwdrv_d = 1'b1;
`ifdef PS16_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = ST_S0;
        end
      end
      ST_S0: begin
        if (mc_clk_falling) begin
          a_d     = addr_q[AW-1:1];
          state_d = ST_S1;
        end
      end
      ST_S1: begin
        if (mc_clk_rising) begin
          as_d = 1'b1;
          if (rw_q) begin
            ds_d  = 1'b1;
            uds_d = uds_sel_n;
            lds_d = lds_sel_n;
          end
          state_d = ST_S2;
        end
      end
      ST_S2: begin
        if (mc_clk_falling) begin
          if (!rw_q) begin
            dbus_d = 1'b1;
            do_d   = wr_word;
          end
          state_d = ST_S3;
        end
      end
      ST_S3: begin
        if (mc_clk_rising) begin
          if (!rw_q) begin
            ds_d  = 1'b1;
            uds_d = uds_sel_n;
            lds_d = lds_sel_n;
          end
          state_d = ST_S4;
        end
      end
      ST_S4, ST_WAIT: begin
        // BERR takes priority over DTACK.
        if (mc_clk_falling) begin
          if (!berr_n_sync) begin
            abort = 1'b1;
          end else if (!dtack_sync) begin
            state_d = ST_S5;
          end else begin
            state_d = ST_WAIT;
`ifdef PS16_BUS_TIMEOUT_EN
            if (state_q == ST_WAIT) begin
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_d == CNT_W'(TIMEOUT_CLKS)) abort = 1'b1;
            end
`endif
          end
        end
      end
      ST_S5: begin
        if (mc_clk_rising) state_d = ST_S6;
      end
      ST_S6: begin
        if (mc_clk_falling) begin
          if (rw_q) rdata_d = rd_merge;
          as_d    = 1'b0;
          ds_d    = 1'b0;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
          state_d = ST_S7;
        end
      end
      ST_S7: begin
        if (mc_clk_rising) begin
          dbus_d = 1'b0;
          if (is_long && !widx_q) begin
            addr_d  = addr_q + 24'd2;
            widx_d  = 1'b1;
`ifdef PS16_BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = ST_S0;
          end else begin
            abus_d   = 1'b0;
            rwdrv_d  = 1'b0;
            rwo_d    = 1'b1;
            normal_d = 1'b1;
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abnormal end: strobes drop now, remaining drives drop in IDLE.
    if (abort) begin
      as_d     = 1'b0;
      ds_d     = 1'b0;
      uds_d    = 1'b1;
      lds_d    = 1'b1;
      normal_d = 1'b0;
      active_d = 1'b0;
      state_d  = ST_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q                 <= ST_IDLE;
      addr_q                  <= '0;
      fc_q                    <= '0;
      rw_q                    <= 1'b1;
      size_q                  <= '0;
      wdata_q                 <= '0;
      widx_q                  <= 1'b0;
      req_active              <= 1'b0;
      req_terminated_normally <= 1'b1;
      req_data_read           <= '0;
      a_out                   <= '0;
      fc_out                  <= '0;
      d_out                   <= '0;
      abus_drive              <= 1'b0;
      dbus_drive              <= 1'b0;
      rw_out                  <= 1'b1;
      rw_drive                <= 1'b0;
      as_drive                <= 1'b0;
      ds_drive                <= 1'b0;
      uds_n                   <= 1'b1;
      lds_n                   <= 1'b1;
`ifdef PS16_BUS_TIMEOUT_EN
      cnt_q                   <= '0;
`endif
    end else begin
      state_q                 <= state_d;
      addr_q                  <= addr_d;
      fc_q                    <= fc_d;
      rw_q                    <= rw_d;
      size_q                  <= size_d;
      wdata_q                 <= wdata_d;
      widx_q                  <= widx_d;
      req_active              <= active_d;
      req_terminated_normally <= normal_d;
      req_data_read           <= rdata_d;
      a_out                   <= a_d;
      fc_out                  <= fco_d;
      d_out                   <= do_d;
      abus_drive              <= abus_d;
      dbus_drive              <= dbus_d;
      rw_out                  <= rwo_d;
      rw_drive                <= rwdrv_d;
      as_drive                <= as_d;
      ds_drive                <= ds_d;
      uds_n                   <= uds_d;
      lds_n                   <= lds_d;
`ifdef PS16_BUS_TIMEOUT_EN
      cnt_q                   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps16_bus_cycle.sv
// Directed bench for ps16_bus_cycle: CLK_7M strobes every 8 sys_clk (rise at
// phase 0, fall at phase 4) and a simple DTACK/BERR responder keyed on AS age.
module tb_ps16_bus_cycle;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        mc_clk_rising = 1'b0;
  logic        mc_clk_falling = 1'b0;
  logic        dtack_sync = 1'b1;
  logic        berr_n_sync = 1'b1;
  logic        is_bm = 1'b1;
  logic        req_start = 1'b0;
  logic [23:0] req_address = '0;
  logic [2:0]  req_fc = '0;
  logic        req_rw = 1'b1;
  logic [1:0]  req_size = '0;
  logic [31:0] req_data_write = '0;
  logic [15:0] d_in = '0;
  logic        req_active, req_terminated_normally;
  logic [31:0] req_data_read;
  logic [22:0] a_out;
  logic [2:0]  fc_out;
  logic [15:0] d_out;
  logic        abus_drive, dbus_drive, rw_out, rw_drive, as_drive, ds_drive, uds_n, lds_n;

  ps16_bus_cycle #(.TIMEOUT_CLKS(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .mc_clk_rising(mc_clk_rising), .mc_clk_falling(mc_clk_falling),
    .dtack_sync(dtack_sync), .berr_n_sync(berr_n_sync), .is_bm(is_bm),
    .req_start(req_start), .req_address(req_address), .req_fc(req_fc),
    .req_rw(req_rw), .req_size(req_size), .req_data_write(req_data_write),
    .d_in(d_in), .req_active(req_active),
    .req_terminated_normally(req_terminated_normally),
    .req_data_read(req_data_read), .a_out(a_out), .fc_out(fc_out), .d_out(d_out),
    .abus_drive(abus_drive), .dbus_drive(dbus_drive), .rw_out(rw_out),
    .rw_drive(rw_drive), .as_drive(as_drive), .ds_drive(ds_drive),
    .uds_n(uds_n), .lds_n(lds_n)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CLK_7M edge strobes.
  int ph = 7;
  always @(negedge sys_clk) begin
    ph = (ph == 7) ? 0 : ph + 1;
    mc_clk_rising  = (ph == 0);
    mc_clk_falling = (ph == 4);
  end

  // Responder: after AS has been low long enough for rsp_wait wait clocks,
  // assert DTACK and/or BERR; d_in follows the word index of a long.
  int          rsp_wait  = 0;
  logic        rsp_dtack = 1'b1;
  logic        rsp_berr  = 1'b0;
  logic [15:0] rsp_w0 = '0, rsp_w1 = '0;
  logic        rsp_word = 1'b0;
  logic        as_prev = 1'b0;
  logic        hit = 1'b0;
  int          as_age = 0;
  always @(negedge sys_clk) begin
    if (!req_active) rsp_word = 1'b0;
    else if (as_prev && !as_drive) rsp_word = 1'b1;
    as_prev = as_drive;
    as_age  = as_drive ? as_age + 1 : 0;
    hit = as_drive && (as_age >= 8 + 8 * rsp_wait);
    dtack_sync  = !(hit && rsp_dtack);
    berr_n_sync = !(hit && rsp_berr);
    d_in = rsp_word ? rsp_w1 : rsp_w0;
  end

  // Per-transfer observations.
  int          r_start, r_end, r_nas, r_nd;
  logic [22:0] r_a1, r_a2;
  logic [15:0] r_d1, r_d2;
  logic        r_rw0, r_u, r_l, r_done;
  logic [2:0]  r_fc0;

  task automatic run_xfer(input logic [23:0] addr, input logic [2:0] fc, input logic rw,
                          input logic [1:0] size, input logic [31:0] wdata, input logic bm_drop);
    int cyc;
    logic pa, pas, pd;
    r_start = -1; r_end = -1; r_nas = 0; r_nd = 0;
    r_a1 = '0; r_a2 = '0; r_d1 = '0; r_d2 = '0;
    r_rw0 = 1'b1; r_u = 1'b0; r_l = 1'b0; r_done = 1'b0; r_fc0 = '0;
    @(negedge sys_clk);
    req_address = addr; req_fc = fc; req_rw = rw; req_size = size;
    req_data_write = wdata; req_start = 1'b1;
    @(posedge sys_clk); #1;
    check("start_active", 32'(req_active), 32'd1);
    @(negedge sys_clk);
    req_start = 1'b0;
    cyc = 1; pa = 1'b0; pas = 1'b0; pd = 1'b0;
    for (int i = 0; i < 800 && !r_done; i++) begin
      @(posedge sys_clk); #1;
      cyc++;
      if (bm_drop && cyc == 24) is_bm = 1'b0;
      if (abus_drive && !pa && r_start < 0) begin
        r_start = cyc; r_rw0 = rw_out; r_fc0 = fc_out;
      end
      if (as_drive && !pas) begin
        r_nas++;
        if (r_nas == 1) r_a1 = a_out; else r_a2 = a_out;
      end
      if (dbus_drive && !pd) begin
        r_nd++;
        if (r_nd == 1) r_d1 = d_out; else r_d2 = d_out;
      end
      if (ds_drive) begin
        if (!uds_n) r_u = 1'b1;
        if (!lds_n) r_l = 1'b1;
      end
      if (!req_active) begin
        r_done = 1'b1; r_end = cyc;
      end
      pa = abus_drive; pas = as_drive; pd = dbus_drive;
    end
    is_bm = 1'b1;
    check("xfer_done", 32'(r_done), 32'd1);
  endtask

  task automatic check_released(input string tag);
    repeat (2) @(posedge sys_clk);
    #1;
    check(tag, 32'({abus_drive, dbus_drive, rw_drive, as_drive, ds_drive, rw_out, uds_n, lds_n}),
          32'b0000_0111);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_active", 32'(req_active), 32'd0);
    check("rst_normal", 32'(req_terminated_normally), 32'd1);
    check("rst_rdata", req_data_read, 32'd0);
    check("rst_drives", 32'({abus_drive, dbus_drive, rw_drive, as_drive, ds_drive}), 32'd0);
    check("rst_levels", 32'({rw_out, uds_n, lds_n}), 32'b111);
    check("rst_buses", 32'(a_out) | 32'(fc_out) | 32'(d_out), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Word read, zero waits
    rsp_w0 = 16'hA5C3; rsp_wait = 0; rsp_dtack = 1'b1; rsp_berr = 1'b0;
    run_xfer(24'hDFF004, 3'b101, 1'b1, 2'd1, 32'h0, 1'b0);
    check("wr_rdata", req_data_read, 32'h0000A5C3);
    check("wr_normal", 32'(req_terminated_normally), 32'd1);
    check("wr_strobes", 32'({r_u, r_l}), 32'b11);
    check("wr_len", 32'(r_end - r_start), 32'd32);
    check("wr_addr", 32'(r_a1), 32'h6FF802);
    check("wr_fc", 32'(r_fc0), 32'b101);
    check_released("wr_release");

    // Byte write at odd address
    run_xfer(24'h000001, 3'b001, 1'b0, 2'd0, 32'h1234567E, 1'b0);
    check("bw_strobes", 32'({r_u, r_l}), 32'b01);
    check("bw_dout", 32'(r_d1), 32'h7E7E);
    check("bw_rw_s0", 32'(r_rw0), 32'd0);
    check("bw_normal", 32'(req_terminated_normally), 32'd1);
    check_released("bw_release");

    // Long read across the 24-bit wrap
    rsp_w0 = 16'h1234; rsp_w1 = 16'h5678;
    run_xfer(24'hFFFFFE, 3'b101, 1'b1, 2'd2, 32'h0, 1'b0);
    check("lr_addr1", 32'(r_a1), 32'h7FFFFF);
    check("lr_addr2", 32'(r_a2), 32'h000000);
    check("lr_rdata", req_data_read, 32'h12345678);
    check("lr_len", 32'(r_end - r_start), 32'd64);
    check("lr_nas", 32'(r_nas), 32'd2);

    // Word read with DTACK delayed three clocks
    rsp_w0 = 16'h0F0F; rsp_wait = 3;
    run_xfer(24'h000010, 3'b101, 1'b1, 2'd3, 32'h0, 1'b0);
    check("wait_len", 32'(r_end - r_start), 32'd56);
    check("wait_normal", 32'(req_terminated_normally), 32'd1);
    check("wait_rdata", req_data_read, 32'h00000F0F);

    // Long write terminated by BERR on the first word
    rsp_wait = 0; rsp_dtack = 1'b0; rsp_berr = 1'b1;
    run_xfer(24'h100000, 3'b001, 1'b0, 2'd2, 32'hDEADBEEF, 1'b0);
    check("berr_nas", 32'(r_nas), 32'd1);
    check("berr_normal", 32'(req_terminated_normally), 32'd0);
    check("berr_len", 32'(r_end - r_start), 32'd20);
    check("berr_dout", 32'(r_d1), 32'hDEAD);
    check("berr_rdata", req_data_read, 32'h00000F0F);
    check_released("berr_release");

    // BERR and DTACK together: BERR wins
    rsp_dtack = 1'b1; rsp_berr = 1'b1; rsp_w0 = 16'hFFFF;
    run_xfer(24'h000020, 3'b101, 1'b1, 2'd1, 32'h0, 1'b0);
    check("both_normal", 32'(req_terminated_normally), 32'd0);
    check("both_rdata", req_data_read, 32'h00000F0F);

    // Long write, normal
    rsp_berr = 1'b0;
    run_xfer(24'h040000, 3'b001, 1'b0, 2'd2, 32'hCAFEBEEF, 1'b0);
    check("lw_d1", 32'(r_d1), 32'hCAFE);
    check("lw_d2", 32'(r_d2), 32'hBEEF);
    check("lw_addr2", 32'(r_a2), 32'h020001);
    check("lw_len", 32'(r_end - r_start), 32'd64);
    check("lw_normal", 32'(req_terminated_normally), 32'd1);

    // Byte reads, odd then even lane
    rsp_w0 = 16'hABCD;
    run_xfer(24'h000101, 3'b101, 1'b1, 2'd0, 32'h0, 1'b0);
    check("br_odd", req_data_read, 32'h000000CD);
    check("br_odd_strb", 32'({r_u, r_l}), 32'b01);
    run_xfer(24'h000100, 3'b101, 1'b1, 2'd0, 32'h0, 1'b0);
    check("br_even", req_data_read, 32'h000000AB);
    check("br_even_strb", 32'({r_u, r_l}), 32'b10);

    // Start ignored without bus ownership
    @(negedge sys_clk);
    is_bm = 1'b0; req_start = 1'b1;
    @(posedge sys_clk); #1;
    check("nobm_active", 32'(req_active), 32'd0);
    @(negedge sys_clk);
    req_start = 1'b0; is_bm = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("nobm_idle", 32'(abus_drive), 32'd0);

    // is_bm drops mid-cycle: cycle still completes
    rsp_w0 = 16'h1357;
    run_xfer(24'h000200, 3'b101, 1'b1, 2'd1, 32'h0, 1'b1);
    check("bmdrop_normal", 32'(req_terminated_normally), 32'd1);
    check("bmdrop_rdata", req_data_read, 32'h00001357);

`ifdef PS16_BUS_TIMEOUT_EN
    // No DTACK: abort after four wait clocks
    rsp_dtack = 1'b0; rsp_berr = 1'b0;
    run_xfer(24'h000300, 3'b101, 1'b1, 2'd1, 32'h0, 1'b0);
    check("to_normal", 32'(req_terminated_normally), 32'd0);
    check("to_len", 32'(r_end - r_start), 32'd52);
    check_released("to_release");
`endif

    // sys_rst while waiting for DTACK
    rsp_dtack = 1'b0; rsp_berr = 1'b0;
    @(negedge sys_clk);
    req_address = 24'h000400; req_rw = 1'b1; req_size = 2'd1; req_start = 1'b1;
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    req_start = 1'b0;
    repeat (29) @(posedge sys_clk);
    #1;
    check("wait_as_held", 32'({req_active, as_drive}), 32'b11);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    check("mrst_status", 32'({req_active, req_terminated_normally}), 32'b01);
    check("mrst_rdata", req_data_read, 32'd0);
    check("mrst_drives", 32'({abus_drive, dbus_drive, rw_drive, as_drive, ds_drive}), 32'd0);
    check("mrst_levels", 32'({rw_out, uds_n, lds_n}), 32'b111);
    check("mrst_buses", 32'(a_out) | 32'(fc_out) | 32'(d_out), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
